// File: rtl/gen_queue_pkg.sv
// Shared helpers for the generic delay-queue family.
//   clog2     : ceiling log2, clog2(1) = 0
//   chan_w    : width of a channel index, never below 1 bit
//   slice_lo  : low bit of a channel's slice in a flattened per-channel bus
package gen_queue_pkg;

   // Ceiling log2 usable in parameter expressions.
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      return result;
   endfunction

   // A single-channel build still needs a 1-bit channel tag.
   function automatic int chan_w(input int channels);
      return (clog2(channels) < 1) ? 1 : clog2(channels);
   endfunction

   // Channel c of a flattened bus lives at [c*width +: width].
   function automatic int slice_lo(input int chan, input int width);
      return chan * width;
   endfunction

endpackage

// File: rtl/gen_delay_ring.sv
// One channel's storage: a DEPTH-entry ring buffer with explicit pointer wrap,
// so DEPTH need not be a power of two.
//   clk, rst : clock, synchronous active-high reset
//   push     : push strobe; refused (and ovf set) while full
//   pdata    : push data
//   pop      : remove the head entry (ignored while empty)
//   head     : entry at the read pointer
//   count    : occupancy 0..DEPTH
//   full     : count == DEPTH
//   afull    : count >= AFULL_LEVEL
//   ovf      : sticky, a push arrived while full
module gen_delay_ring
   import gen_queue_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int DEPTH       = 6,
   parameter int AFULL_LEVEL = 4,
   localparam int PW         = clog2(DEPTH),
   localparam int CNTW       = clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] pdata,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [CNTW-1:0]  count,
   output logic             full,
   output logic             afull,
   output logic             ovf
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0]  count_q, count_d;
   logic             full_q, full_d;
   logic             afull_q, afull_d;
   logic             ovf_q, ovf_d;
   logic             accept_s;
   logic             take_s;

   // Pointer advance with explicit wrap at DEPTH-1.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Next-state for pointers, occupancy and flags.
   always_comb begin
      // full_q is the registered flag: a push is refused at full even if a pop happens now.
      accept_s = push && !full_q;
      take_s   = pop && (count_q != '0);
      wr_ptr_d = accept_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = take_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q + CNTW'(accept_s) - CNTW'(take_s);
      // Flags are registered from the next count so they track count_q exactly.
      full_d   = (count_d == CNTW'(DEPTH));
      afull_d  = (count_d >= CNTW'(AFULL_LEVEL));
      ovf_d    = ovf_q | (push & full_q);
   end

   // Control state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         afull_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         afull_q  <= afull_d;
         ovf_q    <= ovf_d;
      end
   end

   // Entry storage; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (accept_s) begin
         mem_q[wr_ptr_q] <= pdata;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign full  = full_q;
   assign afull = afull_q;
   assign ovf   = ovf_q;

endmodule

// File: rtl/gen_rr_delay_queue.sv
// CHANNELS independent delay rings draining through one registered output
// stage, with a round-robin arbiter picking the source channel.
//   clk, rst : clock, synchronous active-high reset
//   we       : per-channel push strobe
//   idata    : push data, channel c at [c*WIDTH +: WIDTH]
//   full     : per-channel count == DEPTH
//   afull    : per-channel count >= AFULL_LEVEL
//   ovf      : per-channel sticky overflow
//   re       : consumer pop, honoured only while oready
//   wdata    : output-stage data
//   wchan    : source channel of wdata
//   oready   : output stage holds a valid entry
//   empty    : all rings and the output stage are empty
module gen_rr_delay_queue
   import gen_queue_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int DEPTH       = 6,
   parameter int CHANNELS    = 4,
   parameter int AFULL_LEVEL = 4,
   localparam int CW         = chan_w(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS-1:0]       we,
   input  logic [CHANNELS*WIDTH-1:0] idata,
   output logic [CHANNELS-1:0]       full,
   output logic [CHANNELS-1:0]       afull,
   output logic [CHANNELS-1:0]       ovf,
   input  logic                      re,
   output logic [WIDTH-1:0]          wdata,
   output logic [CW-1:0]             wchan,
   output logic                      oready,
   output logic                      empty
);

   localparam int CNTW  = clog2(DEPTH + 1);
   // Channel-indexed tables are padded to a power of two so a CW-bit index never overruns.
   localparam int NSLOT = 1 << CW;

   logic [CNTW-1:0]     count_s [CHANNELS];
   logic [WIDTH-1:0]    head_s [NSLOT];
   logic [NSLOT-1:0]    nonempty_s;
   logic [CHANNELS-1:0] pop_s;

   logic                consume_s, loadable_s, load_s;
   logic                grant_valid_s;
   logic [CW-1:0]       grant_idx_s;
   logic [CW:0]         sum_s;

   logic [WIDTH-1:0]    wdata_q, wdata_d;
   logic [CW-1:0]       wchan_q, wchan_d;
   logic                oready_q, oready_d;
   logic [CW-1:0]       rr_q, rr_d;

   for (genvar c = 0; c < NSLOT; c++) begin : g_chan
      if (c < CHANNELS) begin : g_ring
         gen_delay_ring #(
            .WIDTH       (WIDTH),
            .DEPTH       (DEPTH),
            .AFULL_LEVEL (AFULL_LEVEL)
         ) u_ring (
            .clk   (clk),
            .rst   (rst),
            .push  (we[c]),
            .pdata (idata[slice_lo(c, WIDTH) +: WIDTH]),
            .pop   (pop_s[c]),
            .head  (head_s[c]),
            .count (count_s[c]),
            .full  (full[c]),
            .afull (afull[c]),
            .ovf   (ovf[c])
         );
         assign nonempty_s[c] = (count_s[c] != '0);
      end else begin : g_pad
         assign head_s[c]     = '0;
         assign nonempty_s[c] = 1'b0;
      end
   end

   // Round-robin search over non-empty channels starting at rr_q, wrapping at CHANNELS.
   always_comb begin
      grant_valid_s = 1'b0;
      grant_idx_s   = '0;
      sum_s         = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         // rr_q < CHANNELS and i < CHANNELS, so a single subtraction completes the modulo.
         sum_s = {1'b0, rr_q} + (CW + 1)'(i);
         if (sum_s >= (CW + 1)'(CHANNELS)) begin
            sum_s = sum_s - (CW + 1)'(CHANNELS);
         end else begin
            sum_s = sum_s;
         end
         if (!grant_valid_s && nonempty_s[sum_s[CW-1:0]]) begin
            grant_valid_s = 1'b1;
            grant_idx_s   = sum_s[CW-1:0];
         end else begin
            grant_valid_s = grant_valid_s;
         end
      end
   end

   // Output-stage next state: refill on the same edge as a consume to avoid bubbles.
   always_comb begin
      consume_s  = re && oready_q;
      loadable_s = !oready_q || consume_s;
      load_s     = loadable_s && grant_valid_s;
      wdata_d    = wdata_q;
      wchan_d    = wchan_q;
      oready_d   = oready_q;
      rr_d       = rr_q;
      for (int c = 0; c < CHANNELS; c++) begin
         pop_s[c] = load_s && (grant_idx_s == CW'(c));
      end
      if (load_s) begin
         wdata_d  = head_s[grant_idx_s];
         wchan_d  = grant_idx_s;
         oready_d = 1'b1;
         rr_d     = (grant_idx_s == CW'(CHANNELS - 1)) ? '0 : grant_idx_s + CW'(1);
      end else if (consume_s) begin
         // Nothing to refill: data and tag hold their last values.
         oready_d = 1'b0;
      end else begin
         oready_d = oready_q;
      end
   end

   // Output-stage and arbiter pointer register.
   always_ff @(posedge clk) begin
      if (rst) begin
         wdata_q  <= '0;
         wchan_q  <= '0;
         oready_q <= 1'b0;
         rr_q     <= '0;
      end else begin
         wdata_q  <= wdata_d;
         wchan_q  <= wchan_d;
         oready_q <= oready_d;
         rr_q     <= rr_d;
      end
   end

   assign wdata  = wdata_q;
   assign wchan  = wchan_q;
   assign oready = oready_q;
   assign empty  = !oready_q && (nonempty_s == '0);

endmodule
